// File: rtl/stage_operator_writeback_if.sv
// Operator-output bus into the writeback/mix stage. The algorithm word is laid out as
// [11:4] ModulateWithOP (ignored here), [3] IsACarrier, [2:0] NumCarriers.
interface stage_operator_writeback_if;
    logic               i_Valid;
    logic [7:0]         i_VoiceOperator;
    logic [11:0]        i_AlgorithmWord;
    logic signed [15:0] i_Sample;
    logic [7:0]         o_OperatorWritebackID;
    logic signed [15:0] o_OperatorWritebackValue;
    logic signed [15:0] o_Sample;
    logic               o_SampleValid;
    logic               o_Clipped;

    modport slave (
        input  i_Valid, i_VoiceOperator, i_AlgorithmWord, i_Sample,
        output o_OperatorWritebackID, o_OperatorWritebackValue,
               o_Sample, o_SampleValid, o_Clipped
    );

    modport master (
        output i_Valid, i_VoiceOperator, i_AlgorithmWord, i_Sample,
        input  o_OperatorWritebackID, o_OperatorWritebackValue,
               o_Sample, o_SampleValid, o_Clipped
    );
endinterface

// File: rtl/stage_operator_writeback.sv
// Last operator pipeline stage: writes each operator sample back to the modulator and
// mixes carrier outputs of every voice into one saturated audio sample per frame.
module stage_operator_writeback #(
    parameter int         MIX_SHIFT = 5,
    parameter int         ACC_WIDTH = 24,
    parameter logic [7:0] LAST_ID   = 8'd255
) (
    input logic                    i_Clock,
    input logic                    i_Reset,
    stage_operator_writeback_if.slave bus
);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

    logic [7:0]                  wb_id_reg;
    logic signed [15:0]          wb_value_reg;
    logic                        s1_valid_reg;
    logic                        s1_last_reg;
    logic                        s1_carrier_reg;
    logic signed [31:0]          s1_product_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [15:0]          sample_reg;
    logic                        sample_valid_reg;
    logic                        clipped_reg;

    logic [15:0]                 recip;
    logic signed [31:0]          sample_ext;
    logic signed [31:0]          recip_ext;
    logic signed [31:0]          product;
    logic signed [31:0]          product_shifted;
    logic signed [ACC_WIDTH-1:0] contrib;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic signed [15:0]          sample_next;
    logic                        clipped_next;

    // Q15 reciprocal of the carrier count; a count of 0 is treated as a single carrier.
    always_comb begin
        recip = 16'd32767;
        case (bus.i_AlgorithmWord[2:0])
            3'd2:    recip = 16'd16384;
            3'd3:    recip = 16'd10923;
            3'd4:    recip = 16'd8192;
            3'd5:    recip = 16'd6554;
            3'd6:    recip = 16'd5461;
            3'd7:    recip = 16'd4681;
            default: recip = 16'd32767;
        endcase
    end

    assign sample_ext      = 32'(bus.i_Sample);
    assign recip_ext       = {16'd0, recip};
    assign product         = sample_ext * recip_ext;
    assign product_shifted = s1_product_reg >>> 15;
    assign contrib         = s1_carrier_reg ? ACC_WIDTH'(product_shifted) : '0;
    assign sum             = acc_reg + contrib;
    assign scaled          = sum >>> MIX_SHIFT;

    always_comb begin
        sample_next  = scaled[15:0];
        clipped_next = 1'b0;
        if (scaled > SAT_MAX) begin
            sample_next  = 16'sd32767;
            clipped_next = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sample_next  = -16'sd32768;
            clipped_next = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wb_id_reg        <= '0;
            wb_value_reg     <= '0;
            s1_valid_reg     <= 1'b0;
            s1_last_reg      <= 1'b0;
            s1_carrier_reg   <= 1'b0;
            s1_product_reg   <= '0;
            acc_reg          <= '0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            clipped_reg      <= 1'b0;
        end else begin
            // Holding the last write keeps the modulator's every-cycle write idempotent.
            if (bus.i_Valid) begin
                wb_id_reg    <= bus.i_VoiceOperator;
                wb_value_reg <= bus.i_Sample;
            end

            s1_valid_reg   <= bus.i_Valid;
            s1_last_reg    <= bus.i_Valid && (bus.i_VoiceOperator == LAST_ID);
            s1_carrier_reg <= bus.i_Valid && bus.i_AlgorithmWord[3];
            s1_product_reg <= product;

            sample_valid_reg <= 1'b0;
            clipped_reg      <= 1'b0;
            if (s1_valid_reg) begin
                if (s1_last_reg) begin
                    // Closing entry's own contribution belongs to the frame it closes.
                    sample_reg       <= sample_next;
                    clipped_reg      <= clipped_next;
                    sample_valid_reg <= 1'b1;
                    acc_reg          <= '0;
                end else begin
                    acc_reg <= sum;
                end
            end
        end
    end

    assign bus.o_OperatorWritebackID    = wb_id_reg;
    assign bus.o_OperatorWritebackValue = wb_value_reg;
    assign bus.o_Sample                 = sample_reg;
    assign bus.o_SampleValid            = sample_valid_reg;
    assign bus.o_Clipped                = clipped_reg;
endmodule

// File: tb/tb_stage_operator_writeback.sv
// Bench for stage_operator_writeback: two instances (mix shift 5 and 0) driven in lockstep
// and compared against a frame-level arithmetic reference model.
module tb_stage_operator_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_operator_writeback_if bus5 ();
    stage_operator_writeback_if bus0 ();

    stage_operator_writeback #(.MIX_SHIFT(5), .ACC_WIDTH(24), .LAST_ID(8'd255)) dut5 (
        .i_Clock(clk), .i_Reset(rst), .bus(bus5.slave));
    stage_operator_writeback #(.MIX_SHIFT(0), .ACC_WIDTH(24), .LAST_ID(8'd255)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .bus(bus0.slave));

    typedef struct { int s; int c; } exp_t;
    typedef struct { bit v; logic [7:0] id; int smp; logic [7:0] eid; int evalue; } wb_vec_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     edges = 0;
    exp_t   exp5[int];
    exp_t   exp0[int];
    longint acc_m = 0;
    int     wb_id_m = 0;
    int     wb_val_m = 0;
    int     last_s5, last_c5, last_s0, last_c0;

    always @(posedge clk) edges++;

    task automatic chk(input string name, input longint act, input longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint recip_of(input int nc);
        case (nc)
            2: return 16384;  3: return 10923;  4: return 8192;
            5: return 6554;   6: return 5461;   7: return 4681;
            default: return 32767;
        endcase
    endfunction

    function automatic exp_t finish_frame(input longint total, input int shift);
        exp_t   e;
        longint s = floor_div(total, longint'(1) << shift);
        e.c = 0;
        if (s > 32767)       begin s = 32767;  e.c = 1; end
        else if (s < -32768) begin s = -32768; e.c = 1; end
        e.s = int'(s);
        return e;
    endfunction

    // Called just after a clock edge; the next edge consumes these inputs.
    task automatic step(input bit v, input logic [7:0] id, input bit car,
                        input logic [2:0] nc, input int smp);
        logic [11:0] aw;
        longint      c;
        if (!rst) begin
            chk("wb_id", bus5.o_OperatorWritebackID, wb_id_m);
            chk("wb_value", bus5.o_OperatorWritebackValue, wb_val_m);
            chk("wb_id_b", bus0.o_OperatorWritebackID, wb_id_m);
        end
        aw = {8'($urandom), car, nc};
        bus5.i_Valid = v; bus5.i_VoiceOperator = id; bus5.i_AlgorithmWord = aw; bus5.i_Sample = 16'(smp);
        bus0.i_Valid = v; bus0.i_VoiceOperator = id; bus0.i_AlgorithmWord = aw; bus0.i_Sample = 16'(smp);
        if (v) begin
            wb_id_m  = int'(id);
            wb_val_m = smp;
            c = car ? floor_div(longint'(smp) * recip_of(int'(nc)), 32768) : 0;
            if (id == 8'd255) begin
                exp5[edges + 2] = finish_frame(acc_m + c, 5);
                exp0[edges + 2] = finish_frame(acc_m + c, 0);
                acc_m = 0;
            end else begin
                acc_m += c;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), 3'($urandom), int'($signed(16'($urandom))));
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        bus5.i_Valid = 1'b0;
        bus0.i_Valid = 1'b0;
        exp5.delete();
        exp0.delete();
        acc_m = 0; wb_id_m = 0; wb_val_m = 0;
        #1;
        chk("rst_wb_id", bus5.o_OperatorWritebackID, 0);
        chk("rst_wb_value", bus5.o_OperatorWritebackValue, 0);
        chk("rst_sample", bus5.o_Sample, 0);
        chk("rst_valid", bus5.o_SampleValid, 0);
        chk("rst_clipped", bus0.o_Clipped, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Strobe timing and value are checked every cycle against the scheduled expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp5.exists(edges)) begin
                chk("strobe5_valid", bus5.o_SampleValid, 1);
                chk("strobe5_sample", bus5.o_Sample, exp5[edges].s);
                chk("strobe5_clip", bus5.o_Clipped, exp5[edges].c);
                last_s5 = bus5.o_Sample; last_c5 = bus5.o_Clipped;
                exp5.delete(edges);
            end else begin
                chk("idle5_valid", bus5.o_SampleValid, 0);
                chk("idle5_clip", bus5.o_Clipped, 0);
            end
            if (exp0.exists(edges)) begin
                chk("strobe0_valid", bus0.o_SampleValid, 1);
                chk("strobe0_sample", bus0.o_Sample, exp0[edges].s);
                chk("strobe0_clip", bus0.o_Clipped, exp0[edges].c);
                last_s0 = bus0.o_Sample; last_c0 = bus0.o_Clipped;
                exp0.delete(edges);
            end else begin
                chk("idle0_valid", bus0.o_SampleValid, 0);
            end
        end
    end

    task automatic clear_last();
        last_s5 = -99999; last_c5 = -1; last_s0 = -99999; last_c0 = -1;
    endtask

    // One voice (last voice, ops 0..7); ops below ncar are carriers with the same sample.
    task automatic voice_frame(input int ncar, input logic [2:0] nc, input int smp);
        for (int op = 0; op < 8; op++)
            step(1'b1, 8'(248 + op), op < ncar, nc, op < ncar ? smp : 1234);
        idle(3);
    endtask

    initial begin
        wb_vec_t wbv[6];
        wbv[0] = '{1'b1, 8'h2A, -1234,  8'h2A, -1234};
        wbv[1] = '{1'b0, 8'h55, 777,    8'h2A, -1234};
        wbv[2] = '{1'b0, 8'h11, 5,      8'h2A, -1234};
        wbv[3] = '{1'b1, 8'h80, 32767,  8'h80, 32767};
        wbv[4] = '{1'b1, 8'h01, -32768, 8'h01, -32768};
        wbv[5] = '{1'b0, 8'hFF, 99,     8'h01, -32768};

        bus5.i_Valid = 0; bus5.i_VoiceOperator = 0; bus5.i_AlgorithmWord = 0; bus5.i_Sample = 0;
        bus0.i_Valid = 0; bus0.i_VoiceOperator = 0; bus0.i_AlgorithmWord = 0; bus0.i_Sample = 0;
        clear_last();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            step(wbv[i].v, wbv[i].id, 1'b0, 3'd1, wbv[i].smp);
            $display("wb vector %0d: id=%0h value=%0d", i, bus5.o_OperatorWritebackID, bus5.o_OperatorWritebackValue);
            chk("wb_vec_id", bus5.o_OperatorWritebackID, wbv[i].eid);
            chk("wb_vec_value", bus5.o_OperatorWritebackValue, wbv[i].evalue);
        end

        // Full frame with a single carrier at ID 8
        clear_last();
        for (int id = 0; id < 256; id++)
            step(1'b1, 8'(id), id == 8, 3'd1, id == 8 ? 16000 : 5000);
        idle(3);
        $display("single carrier frame: s5=%0d s0=%0d", last_s5, last_s0);
        chk("single_s5", last_s5, 499);
        chk("single_c5", last_c5, 0);
        chk("single_s0", last_s0, 15999);

        async_reset();
        idle(300);

        clear_last();
        voice_frame(3, 3'd3, 30000);
        $display("three carriers nc=3: s0=%0d s5=%0d", last_s0, last_s5);
        chk("nc3_s0", last_s0, 30000);
        chk("nc3_c0", last_c0, 0);
        chk("nc3_s5", last_s5, 937);

        clear_last();
        voice_frame(3, 3'd0, 30000);
        $display("three carriers nc=0: s0=%0d clip=%0d", last_s0, last_c0);
        chk("nc0_s0", last_s0, 32767);
        chk("nc0_c0", last_c0, 1);
        chk("nc0_s5", last_s5, 2812);

        clear_last();
        voice_frame(4, 3'd1, -30000);
        $display("negative saturation: s0=%0d clip=%0d", last_s0, last_c0);
        chk("neg_s0", last_s0, -32768);
        chk("neg_c0", last_c0, 1);
        chk("neg_s5", last_s5, -3750);

        clear_last();
        voice_frame(0, 3'd1, 0);
        $display("zero frame: s0=%0d clip=%0d", last_s0, last_c0);
        chk("zero_s0", last_s0, 0);
        chk("zero_c0", last_c0, 0);

        clear_last();
        step(1'b1, 8'd255, 1'b1, 3'd1, 3200);
        step(1'b1, 8'd255, 1'b1, 3'd1, 3200);
        idle(3);
        $display("back-to-back last: s5=%0d", last_s5);
        chk("b2b_s5", last_s5, 99);

        // Randomised frames with bubbles, including one reset landing mid-frame
        for (int f = 0; f < 60; f++) begin
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 3) == 0) idle(1);
                if (f == 30 && i == n / 2) async_reset();
                step(1'b1, (i == n - 1) ? 8'd255 : 8'($urandom_range(0, 254)),
                     1'($urandom), 3'($urandom), int'($signed(16'($urandom))));
            end
            $display("random frame %0d: %0d entries", f, n);
        end
        idle(4);
        chk("pending_strobes", exp5.num() + exp0.num(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
